// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - byte read port between the uart_rx_ctrl FIFO and its consumer
//   rd_valid  FIFO non-empty (driven by the controller)
//   rd_data   FIFO head byte, first-word fall-through (driven by the controller)
//   rd_ready  consumer pop request; a pop happens when rd_valid & rd_ready
interface uart_rx_ctrl_if;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - uart_rx enable/baud gating, receive FIFO and interrupt generation
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cfg_*                  enable, clocks per bit, watermark, timeout bit-times
//   fifo_clr_i, intr_clr_i FIFO flush pulse, W1C {timeout, overflow, watermark}
//   rx_dv_i, rx_byte_i     byte strobe and byte from uart_rx
//   rx_en_o, clks_per_bit_o drive uart_rx
//   rd                     read port (uart_rx_ctrl_if.master)
//   fifo_level_o, fifo_full_o, state_o, intr_*_o status and interrupts
module uart_rx_ctrl #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           cfg_en_i,
    input  logic [15:0]    cfg_clks_per_bit_i,
    input  logic [AW:0]    cfg_watermark_i,
    input  logic [7:0]     cfg_timeout_bits_i,
    input  logic           fifo_clr_i,
    input  logic [2:0]     intr_clr_i,
    input  logic           rx_dv_i,
    input  logic [7:0]     rx_byte_i,
    output logic           rx_en_o,
    output logic [15:0]    clks_per_bit_o,
    output logic [AW:0]    fifo_level_o,
    output logic           fifo_full_o,
    output logic [1:0]     state_o,
    output logic           intr_watermark_o,
    output logic           intr_overflow_o,
    output logic           intr_timeout_o,
    uart_rx_ctrl_if.master rd
);

    typedef enum logic [1:0] {
        ST_OFF     = 2'b00,
        ST_RUN     = 2'b01,
        ST_QUIESCE = 2'b10
    } state_e;

    // A full frame is start + 8 data + parity/stop margin: 11 bit-times
    // is long enough for any frame already in flight to land.
    localparam logic [3:0]  QUIESCE_LAST_TICK = 4'd10;
    localparam logic [AW:0] LEVEL_FULL        = (AW+1)'(DEPTH);

    state_e        state_q;
    logic [15:0]   bit_cnt_q;
    logic [15:0]   bit_cnt_nxt;
    logic [3:0]    q_ticks_q;
    logic          bit_tick;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          ovf_evt;

    logic [7:0]    idle_q;
    logic [7:0]    idle_nxt;
    logic          idle_clr;
    logic          to_fired_q;
    logic          to_evt;

    logic          unused_intr_clr;

    // intr_clr_i[0] targets the watermark interrupt, which is level based
    // and has nothing to clear.
    assign unused_intr_clr = intr_clr_i[0];

    // ------------------------------------------------------------------
    // Bit-tick generator and receiver FSM
    // ------------------------------------------------------------------
    assign bit_tick = (state_q != ST_OFF) && (bit_cnt_q == clks_per_bit_o - 16'd1);

    always_comb begin
        bit_cnt_nxt = bit_cnt_q + 16'd1;
        // rx_dv_i marks a frame boundary, so bit timing re-aligns to it.
        if (rx_dv_i || bit_tick) begin
            bit_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_OFF;
            rx_en_o        <= 1'b0;
            clks_per_bit_o <= 16'd2;
            bit_cnt_q      <= '0;
            q_ticks_q      <= '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    clks_per_bit_o <= cfg_clks_per_bit_i;
                    bit_cnt_q      <= '0;
                    q_ticks_q      <= '0;
                    if (cfg_en_i && (cfg_clks_per_bit_i >= 16'd2)) begin
                        state_q <= ST_RUN;
                        rx_en_o <= 1'b1;
                    end
                end
                ST_RUN: begin
                    bit_cnt_q <= bit_cnt_nxt;
                    if (!cfg_en_i || (cfg_clks_per_bit_i != clks_per_bit_o)) begin
                        state_q   <= ST_QUIESCE;
                        rx_en_o   <= 1'b0;
                        bit_cnt_q <= '0;
                        q_ticks_q <= '0;
                    end
                end
                ST_QUIESCE: begin
                    if (rx_dv_i || (bit_tick && (q_ticks_q == QUIESCE_LAST_TICK))) begin
                        state_q   <= ST_OFF;
                        bit_cnt_q <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_nxt;
                        if (bit_tick) begin
                            q_ticks_q <= q_ticks_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_OFF;
                    rx_en_o <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_q;

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LEVEL_FULL);
    assign pop        = rd.rd_valid && rd.rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = rx_dv_i && (!fifo_full || pop);
    assign ovf_evt    = rx_dv_i && fifo_full && !pop && !fifo_clr_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (fifo_clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= rx_byte_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign rd.rd_valid   = !fifo_empty;
    assign rd.rd_data    = mem_q[rd_ptr_q];
    assign fifo_level_o  = level_q;
    assign fifo_full_o   = fifo_full;

    // ------------------------------------------------------------------
    // Character timeout
    // ------------------------------------------------------------------
    assign idle_clr = push || pop || fifo_clr_i || fifo_empty;

    always_comb begin
        idle_nxt = idle_q;
        if (idle_clr) begin
            idle_nxt = '0;
        end else if (bit_tick && (idle_q != 8'hFF)) begin
            idle_nxt = idle_q + 8'd1;
        end
    end

    // Fires on the edge where the count reaches the threshold; to_fired_q
    // keeps a saturated count from firing again until traffic re-arms it.
    assign to_evt = !to_fired_q && (cfg_timeout_bits_i != 8'd0) &&
                    (idle_nxt == cfg_timeout_bits_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_q     <= '0;
            to_fired_q <= 1'b0;
        end else begin
            idle_q     <= idle_nxt;
            to_fired_q <= idle_clr ? 1'b0 : (to_fired_q || to_evt);
        end
    end

    // ------------------------------------------------------------------
    // Interrupts: a set event beats a simultaneous clear
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            intr_overflow_o <= 1'b0;
            intr_timeout_o  <= 1'b0;
        end else begin
            intr_overflow_o <= ovf_evt || (intr_overflow_o && !intr_clr_i[1]);
            intr_timeout_o  <= to_evt  || (intr_timeout_o  && !intr_clr_i[2]);
        end
    end

    assign intr_watermark_o = (cfg_watermark_i != '0) && (level_q >= cfg_watermark_i);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard testbench for uart_rx_ctrl
module tb_uart_rx_ctrl;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en;
    logic [15:0] cfg_cpb;
    logic [AW:0] cfg_wm;
    logic [7:0]  cfg_to;
    logic        fifo_clr;
    logic [2:0]  intr_clr;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        rx_en;
    logic [15:0] cpb_o;
    logic [AW:0] level;
    logic        full;
    logic [1:0]  state;
    logic        intr_wm;
    logic        intr_ovf;
    logic        intr_to;

    uart_rx_ctrl_if rd_if ();

    uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .cfg_en_i           (cfg_en),
        .cfg_clks_per_bit_i (cfg_cpb),
        .cfg_watermark_i    (cfg_wm),
        .cfg_timeout_bits_i (cfg_to),
        .fifo_clr_i         (fifo_clr),
        .intr_clr_i         (intr_clr),
        .rx_dv_i            (rx_dv),
        .rx_byte_i          (rx_byte),
        .rx_en_o            (rx_en),
        .clks_per_bit_o     (cpb_o),
        .fifo_level_o       (level),
        .fifo_full_o        (full),
        .state_o            (state),
        .intr_watermark_o   (intr_wm),
        .intr_overflow_o    (intr_ovf),
        .intr_timeout_o     (intr_to),
        .rd                 (rd_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
    endtask

    // Reference model: expected FIFO contents and overflow flag.
    logic [7:0] mdl_q[$];
    logic       mdl_ovf;
    logic       mdl_ev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_q.delete();
            mdl_ovf = 1'b0;
        end else begin
            mdl_ev = 1'b0;
            if (fifo_clr) begin
                mdl_q.delete();
            end else if (rx_dv) begin
                if (mdl_q.size() < DEPTH) mdl_q.push_back(rx_byte);
                else mdl_ev = 1'b1;
            end
            mdl_ovf = mdl_ev | (mdl_ovf & ~intr_clr[1]);
        end
    end

    // Monitor: compares the read port and status against the model each cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rd_valid", 32'(rd_if.rd_valid), 32'(mdl_q.size() != 0));
            chk("level", 32'(level), 32'(mdl_q.size()));
            chk("full", 32'(full), 32'(mdl_q.size() == DEPTH));
            chk("overflow", 32'(intr_ovf), 32'(mdl_ovf));
            chk("watermark", 32'(intr_wm), 32'((cfg_wm != 0) && (mdl_q.size() >= int'(cfg_wm))));
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                if (mdl_q.size() == 0) begin
                    chk("pop_on_empty", 32'(rd_if.rd_valid), 32'd0);
                end else begin
                    chk("rd_data", 32'(rd_if.rd_data), 32'(mdl_q[0]));
                    void'(mdl_q.pop_front());
                end
            end
        end
    end

    logic [7:0] first_b;

    initial begin
        cfg_en         = 1'b1;
        cfg_cpb        = 16'd8;
        cfg_wm         = '0;
        cfg_to         = 8'd0;
        fifo_clr       = 1'b0;
        intr_clr       = 3'b000;
        rx_dv          = 1'b0;
        rx_byte        = 8'h00;
        rd_if.rd_ready = 1'b0;

        // Reset values and first transition to RUN
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_rx_en", 32'(rx_en), 32'd0);
        chk("rst_cpb", 32'(cpb_o), 32'd2);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rd_data", 32'(rd_if.rd_data), 32'd0);
        chk("rst_intr", 32'({intr_wm, intr_ovf, intr_to}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("off_before_edge", 32'(state), 32'd0);
        @(negedge clk);
        chk("run_state", 32'(state), 32'd1);
        chk("run_rx_en", 32'(rx_en), 32'd1);
        chk("run_cpb", 32'(cpb_o), 32'd8);

        // Three bytes then in-order drain
        tick();
        push(8'hA5);
        push(8'h3C);
        push(8'hFF);
        @(negedge clk);
        chk("three_level", 32'(level), 32'd3);
        chk("three_head", 32'(rd_if.rd_data), 32'hA5);
        tick();
        rd_if.rd_ready = 1'b1;
        repeat (3) tick();
        rd_if.rd_ready = 1'b0;
        @(negedge clk);
        chk("drained_valid", 32'(rd_if.rd_valid), 32'd0);

        // Overflow: 17 pushes into 16 entries
        tick();
        first_b = 8'($urandom);
        push(first_b);
        for (int i = 1; i < 17; i++) push(8'($urandom));
        @(negedge clk);
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_intr", 32'(intr_ovf), 32'd1);
        chk("ovf_head", 32'(rd_if.rd_data), 32'(first_b));
        tick();
        intr_clr = 3'b010;
        tick();
        intr_clr = 3'b000;
        @(negedge clk);
        chk("ovf_cleared", 32'(intr_ovf), 32'd0);

        // Full FIFO with simultaneous push and pop; watermark
        tick();
        cfg_wm         = 5'd4;
        rx_dv          = 1'b1;
        rx_byte        = 8'h77;
        rd_if.rd_ready = 1'b1;
        tick();
        rx_dv          = 1'b0;
        rd_if.rd_ready = 1'b0;
        @(negedge clk);
        chk("pp_level", 32'(level), 32'd16);
        chk("pp_ovf", 32'(intr_ovf), 32'd0);
        tick();
        rd_if.rd_ready = 1'b1;
        repeat (12) tick();
        rd_if.rd_ready = 1'b0;
        @(negedge clk);
        chk("wm_level", 32'(level), 32'd4);
        chk("wm_set", 32'(intr_wm), 32'd1);
        tick();
        rd_if.rd_ready = 1'b1;
        repeat (3) tick();
        rd_if.rd_ready = 1'b0;
        @(negedge clk);
        chk("tail_byte", 32'(rd_if.rd_data), 32'h77);
        chk("wm_clear", 32'(intr_wm), 32'd0);
        tick();
        rd_if.rd_ready = 1'b1;
        tick();
        rd_if.rd_ready = 1'b0;
        cfg_wm = '0;

        // Character timeout: cpb 8, 4 bit-times -> 32 cycles after the push
        cfg_to = 8'd4;
        tick();
        push(8'h11);
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("to_cycle%0d", i), 32'(intr_to), 32'(i == 32));
        end
        tick();
        intr_clr = 3'b100;
        tick();
        intr_clr = 3'b000;
        @(negedge clk);
        chk("to_cleared", 32'(intr_to), 32'd0);
        repeat (40) tick();
        @(negedge clk);
        chk("to_not_rearmed", 32'(intr_to), 32'd0);
        tick();
        push(8'h22);
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i >= 31) chk($sformatf("to2_cycle%0d", i), 32'(intr_to), 32'(i == 32));
        end
        tick();
        intr_clr       = 3'b100;
        rd_if.rd_ready = 1'b1;
        tick();
        intr_clr       = 3'b000;
        tick();
        rd_if.rd_ready = 1'b0;
        cfg_to         = 8'd0;

        // Baud change: QUIESCE for 11 bit-times of 8 clocks
        tick();
        cfg_cpb = 16'd16;
        tick();
        @(negedge clk);
        chk("q_state", 32'(state), 32'd2);
        chk("q_rx_en", 32'(rx_en), 32'd0);
        chk("q_cpb_held", 32'(cpb_o), 32'd8);
        for (int i = 1; i <= 88; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 87) chk("q_still_87", 32'(state), 32'd2);
            if (i == 88) chk("q_off_88", 32'(state), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("rerun_state", 32'(state), 32'd1);
        chk("rerun_cpb", 32'(cpb_o), 32'd16);
        chk("rerun_rx_en", 32'(rx_en), 32'd1);

        // Late byte ends QUIESCE early
        tick();
        cfg_cpb = 16'd12;
        tick();
        repeat (4) tick();
        push(8'h5A);
        @(negedge clk);
        chk("dv_off", 32'(state), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("dv_rerun", 32'(state), 32'd1);
        chk("dv_cpb", 32'(cpb_o), 32'd12);

        // Async reset while in QUIESCE
        tick();
        push(8'h6B);
        cfg_cpb = 16'd8;
        tick();
        @(negedge clk);
        chk("rq_state", 32'(state), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rq_rst_state", 32'(state), 32'd0);
        chk("rq_rst_rx_en", 32'(rx_en), 32'd0);
        chk("rq_rst_cpb", 32'(cpb_o), 32'd2);
        chk("rq_rst_level", 32'(level), 32'd0);
        chk("rq_rst_valid", 32'(rd_if.rd_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rq_rerun", 32'(state), 32'd1);
        chk("rq_rerun_cpb", 32'(cpb_o), 32'd8);

        // Randomized traffic: fill-biased phase then drain-biased phase
        tick();
        cfg_wm = 5'd5;
        for (int c = 0; c < 2000; c++) begin
            rx_dv          = ($urandom_range(0, 9) < ((c < 1000) ? 6 : 3));
            rx_byte        = 8'($urandom);
            rd_if.rd_ready = ($urandom_range(0, 9) < ((c < 1000) ? 3 : 6));
            fifo_clr       = ($urandom_range(0, 99) == 0);
            intr_clr       = {1'b0, ($urandom_range(0, 15) == 0), 1'b0};
            tick();
        end
        rx_dv          = 1'b0;
        fifo_clr       = 1'b0;
        intr_clr       = 3'b000;
        rd_if.rd_ready = 1'b1;
        repeat (20) tick();
        rd_if.rd_ready = 1'b0;
        @(negedge clk);
        chk("final_empty", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
